// File: rtl/cc_bus_microsequencer.sv
// Per-instruction read-A / read-B / execute / write-back sequencer feeding the
// register/control bus selector mux, with a start/busy/done handshake.
module cc_bus_microsequencer #(
    parameter int DATAWIDTH_MUX_SELECTION_REG     = 5,
    parameter int DATAWIDTH_MUX_SELECTION_CONTROL = 6,
    parameter int DATAWIDTH_OPCODE                = 4,
    parameter int NUM_REGS                        = 12,
    parameter int EXEC_WAIT_CYCLES                = 2
) (
    input  logic                                       CC_MICROSEQ_CLOCK_50,
    input  logic                                       CC_MICROSEQ_RESET_InHigh,
    input  logic                                       CC_MICROSEQ_start_In,
    input  logic [DATAWIDTH_MUX_SELECTION_REG-1:0]     CC_MICROSEQ_rs1_InBUS,
    input  logic [DATAWIDTH_MUX_SELECTION_REG-1:0]     CC_MICROSEQ_rs2_InBUS,
    input  logic [DATAWIDTH_MUX_SELECTION_REG-1:0]     CC_MICROSEQ_rd_InBUS,
    input  logic [DATAWIDTH_OPCODE-1:0]                CC_MICROSEQ_opcode_InBUS,
    output logic [DATAWIDTH_MUX_SELECTION_REG-1:0]     CC_MICROSEQ_registro_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] CC_MICROSEQ_control_OutBUS,
    output logic                                       CC_MICROSEQ_selector_Out,
    output logic                                       CC_MICROSEQ_latchA_Out,
    output logic                                       CC_MICROSEQ_latchB_Out,
    output logic                                       CC_MICROSEQ_aluGo_Out,
    output logic                                       CC_MICROSEQ_writeEnable_Out,
    output logic                                       CC_MICROSEQ_busy_Out,
    output logic                                       CC_MICROSEQ_done_Out,
    output logic                                       CC_MICROSEQ_error_Out
);

    localparam int RegW = DATAWIDTH_MUX_SELECTION_REG;
    localparam int CtlW = DATAWIDTH_MUX_SELECTION_CONTROL;
    localparam int OpW  = DATAWIDTH_OPCODE;
    // A zero-length execute phase still needs one cycle for the ALU launch.
    localparam int WaitCycles = (EXEC_WAIT_CYCLES < 1) ? 1 : EXEC_WAIT_CYCLES;
    localparam int CntW = (WaitCycles < 2) ? 1 : $clog2(WaitCycles);

    localparam logic [CntW-1:0] CntLoad = CntW'(WaitCycles - 1);
    localparam logic [RegW-1:0] NumRegs = RegW'(NUM_REGS);
    localparam logic [OpW-1:0]  OpMax   = OpW'(11);

    typedef enum logic [2:0] {
        IDLE, READ_A, READ_B, EXEC, WRITE, DONE
    } state_t;

    state_t          state;
    logic [RegW-1:0] rs1Q;
    logic [RegW-1:0] rs2Q;
    logic [RegW-1:0] rdQ;
    logic [OpW-1:0]  opQ;
    logic [CntW-1:0] waitCnt;
    logic            errQ;
    logic            illegal;

    assign illegal = (CC_MICROSEQ_rs1_InBUS >= NumRegs)
                   | (CC_MICROSEQ_rs2_InBUS >= NumRegs)
                   | (CC_MICROSEQ_rd_InBUS >= NumRegs)
                   | (CC_MICROSEQ_opcode_InBUS > OpMax);

    always_ff @(posedge CC_MICROSEQ_CLOCK_50) begin
        if (CC_MICROSEQ_RESET_InHigh) begin
            state   <= IDLE;
            rs1Q    <= '0;
            rs2Q    <= '0;
            rdQ     <= '0;
            opQ     <= '0;
            waitCnt <= '0;
            errQ    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (CC_MICROSEQ_start_In) begin
                        rs1Q  <= CC_MICROSEQ_rs1_InBUS;
                        rs2Q  <= CC_MICROSEQ_rs2_InBUS;
                        rdQ   <= CC_MICROSEQ_rd_InBUS;
                        opQ   <= CC_MICROSEQ_opcode_InBUS;
                        errQ  <= illegal;
                        state <= illegal ? DONE : READ_A;
                    end
                end
                READ_A: state <= READ_B;
                READ_B: begin
                    waitCnt <= CntLoad;
                    state   <= EXEC;
                end
                EXEC: begin
                    if (waitCnt == '0) state <= WRITE;
                    else waitCnt <= waitCnt - CntW'(1);
                end
                WRITE: state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        CC_MICROSEQ_registro_OutBUS = '0;
        CC_MICROSEQ_control_OutBUS  = '0;
        CC_MICROSEQ_selector_Out    = 1'b0;
        CC_MICROSEQ_latchA_Out      = 1'b0;
        CC_MICROSEQ_latchB_Out      = 1'b0;
        CC_MICROSEQ_aluGo_Out       = 1'b0;
        CC_MICROSEQ_writeEnable_Out = 1'b0;
        CC_MICROSEQ_busy_Out        = (state != IDLE);
        CC_MICROSEQ_done_Out        = 1'b0;
        CC_MICROSEQ_error_Out       = 1'b0;
        unique case (state)
            READ_A: begin
                CC_MICROSEQ_selector_Out    = 1'b1;
                CC_MICROSEQ_registro_OutBUS = rs1Q;
                CC_MICROSEQ_latchA_Out      = 1'b1;
            end
            READ_B: begin
                CC_MICROSEQ_selector_Out    = 1'b1;
                CC_MICROSEQ_registro_OutBUS = rs2Q;
                CC_MICROSEQ_latchB_Out      = 1'b1;
            end
            EXEC: begin
                CC_MICROSEQ_control_OutBUS = CtlW'(opQ);
                CC_MICROSEQ_aluGo_Out      = (waitCnt == CntLoad);
            end
            WRITE: begin
                CC_MICROSEQ_selector_Out    = 1'b1;
                CC_MICROSEQ_registro_OutBUS = rdQ;
                CC_MICROSEQ_writeEnable_Out = (rdQ != '0);
            end
            DONE: begin
                CC_MICROSEQ_done_Out  = 1'b1;
                CC_MICROSEQ_error_Out = errQ;
            end
            default: ;
        endcase
    end

endmodule
